// File: rtl/alu_pkg.sv
// ALU op codes, sequencer command codes and sequencer state encoding.
// ALU_SEQ_WIDE_EN adds the 16-bit commands and the high-byte states.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_INC = 3'd2;
    localparam logic [2:0] ALU_DEC = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_XOR = 3'd6;
    localparam logic [2:0] ALU_ADC = 3'd7;

    localparam logic [3:0] CMD_ADD16 = 4'd8;
    localparam logic [3:0] CMD_INC16 = 4'd9;
    localparam logic [3:0] CMD_AND16 = 4'd10;
    localparam logic [3:0] CMD_OR16  = 4'd11;
    localparam logic [3:0] CMD_XOR16 = 4'd12;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_LO = 3'd1,
        WAIT_LO  = 3'd2,
`ifdef ALU_SEQ_WIDE_EN
        ISSUE_HI = 3'd3,
        WAIT_HI  = 3'd4,
`endif
        RESP     = 3'd5
    } state_t;

    // ALU op for the low byte; 8-bit commands pass straight through.
    function automatic logic [2:0] lo_op(input logic [3:0] cmd);
        logic [2:0] op;
        op = cmd[2:0];
        case (cmd)
            CMD_ADD16: op = ALU_ADD;
            CMD_INC16: op = ALU_INC;
            CMD_AND16: op = ALU_AND;
            CMD_OR16:  op = ALU_OR;
            CMD_XOR16: op = ALU_XOR;
            default:   op = cmd[2:0];
        endcase
        return op;
    endfunction

    // ALU op for the high byte: arithmetic chains through the ALU carry flag.
    function automatic logic [2:0] hi_op(input logic [3:0] cmd);
        logic [2:0] op;
        if ((cmd == CMD_ADD16) || (cmd == CMD_INC16))
            op = ALU_ADC;
        else
            op = lo_op(cmd);
        return op;
    endfunction

endpackage

// File: rtl/alu.sv
// Registered 8-bit ALU: result and flags update one cycle after enable.
// Carry holds the borrow for SUB/DEC; ADC adds the stored carry flag.
module alu
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] out,
    output logic       zero,
    output logic       carry
);

    logic [8:0] w_res;
    logic [7:0] r_out;
    logic       r_zero;
    logic       r_carry;

    // 9-bit result, bit 8 is carry-out or borrow
    always_comb begin
        w_res = 9'd0;
        case (op)
            ALU_ADD: w_res = {1'b0, a} + {1'b0, b};
            ALU_SUB: w_res = {1'b0, a} - {1'b0, b};
            ALU_INC: w_res = {1'b0, a} + 9'd1;
            ALU_DEC: w_res = {1'b0, a} - 9'd1;
            ALU_AND: w_res = {1'b0, a & b};
            ALU_OR:  w_res = {1'b0, a | b};
            ALU_XOR: w_res = {1'b0, a ^ b};
            ALU_ADC: w_res = {1'b0, a} + {1'b0, b} + {8'd0, r_carry};
            default: w_res = 9'd0;
        endcase
    end

    // Result and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out   <= 8'd0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (enable) begin
            r_out   <= w_res[7:0];
            r_zero  <= (w_res[7:0] == 8'd0);
            r_carry <= w_res[8];
        end
    end

    assign out   = r_out;
    assign zero  = r_zero;
    assign carry = r_carry;

endmodule

// File: rtl/alu_seq.sv
// Command sequencer driving an external registered 8-bit ALU.
// ALU_SEQ_WIDE_EN compiles in 16-bit commands 8-12; without it they are reserved.
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | ready for a command
// ISSUE_LO | low bytes presented, alu_enable high
// WAIT_LO  | capture low-byte result and flags
// ISSUE_HI | high bytes presented, alu_enable high (wide only)
// WAIT_HI  | capture high-byte result, merge flags (wide only)
// RESP     | response held until rsp_ready
module alu_seq
    import alu_pkg::*;
#(
    parameter logic [15:0] RESERVED_DATA = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_carry,
    output logic        rsp_err,
    output logic        alu_enable,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_out,
    input  logic        alu_zero,
    input  logic        alu_carry
);

`ifdef ALU_SEQ_WIDE_EN
    localparam int OPW = 16;
    logic [7:0] r_res_hi;
    logic       w_wide;
    logic       w_arith16;
`else
    localparam int OPW = 8;
    logic       w_unused;
    assign w_unused = ^{cmd_a[15:8], cmd_b[15:8]};
`endif

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_op;
    logic [OPW-1:0]   r_a;
    logic [OPW-1:0]   r_b;
    logic [7:0]       r_res_lo;
    logic             r_zero;
    logic             r_carry;
    logic             r_err;
    logic             w_accept;
    logic             w_reserved;

`ifdef ALU_SEQ_WIDE_EN
    assign w_reserved = (cmd_op > CMD_XOR16);
    assign w_wide     = (r_op >= CMD_ADD16);
    assign w_arith16  = (r_op == CMD_ADD16) || (r_op == CMD_INC16);
`else
    assign w_reserved = cmd_op[3];
`endif

    assign w_accept = cmd_valid & cmd_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next state and handshake/ALU drive; reset forces all strobes low
    always_comb begin
        w_next     = r_state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        alu_enable = 1'b0;
        alu_op     = lo_op(r_op);
        alu_a      = r_a[7:0];
        alu_b      = r_b[7:0];
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    w_next = w_reserved ? RESP : ISSUE_LO;
            end
            ISSUE_LO: begin
                alu_enable = 1'b1;
                w_next     = WAIT_LO;
            end
            WAIT_LO: begin
`ifdef ALU_SEQ_WIDE_EN
                w_next = w_wide ? ISSUE_HI : RESP;
`else
                w_next = RESP;
`endif
            end
`ifdef ALU_SEQ_WIDE_EN
            ISSUE_HI: begin
                alu_enable = 1'b1;
                alu_op     = hi_op(r_op);
                alu_a      = r_a[15:8];
                alu_b      = (r_op == CMD_INC16) ? 8'h00 : r_b[15:8];
                w_next     = WAIT_HI;
            end
            WAIT_HI: begin
                w_next = RESP;
            end
`endif
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (reset) begin
            cmd_ready  = 1'b0;
            rsp_valid  = 1'b0;
            alu_enable = 1'b0;
        end
    end

    // Command capture and result/flag accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= 4'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_res_lo <= 8'd0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_err    <= 1'b0;
`ifdef ALU_SEQ_WIDE_EN
            r_res_hi <= 8'd0;
`endif
        end else if (w_accept) begin
            r_op     <= cmd_op;
            r_a      <= cmd_a[OPW-1:0];
            r_b      <= cmd_b[OPW-1:0];
            r_res_lo <= 8'd0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_err    <= w_reserved;
`ifdef ALU_SEQ_WIDE_EN
            r_res_hi <= 8'd0;
`endif
        end else if (r_state == WAIT_LO) begin
            r_res_lo <= alu_out;
            r_zero   <= alu_zero;
            r_carry  <= alu_carry;
        end
`ifdef ALU_SEQ_WIDE_EN
        else if (r_state == WAIT_HI) begin
            r_res_hi <= alu_out;
            r_zero   <= r_zero & alu_zero;
            r_carry  <= w_arith16 & alu_carry;
        end
`endif
    end

`ifdef ALU_SEQ_WIDE_EN
    assign rsp_data = r_err ? RESERVED_DATA : {r_res_hi, r_res_lo};
`else
    assign rsp_data = r_err ? RESERVED_DATA : {8'h00, r_res_lo};
`endif
    assign rsp_zero  = r_zero;
    assign rsp_carry = r_carry;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq closed around alu. Expectations follow ALU_SEQ_WIDE_EN.
module tb_alu_seq;

    localparam logic [15:0] RSV = 16'hBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_carry;
    logic        rsp_err;
    logic        alu_enable;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_out;
    logic        alu_zero;
    logic        alu_carry;

    always #5 clk = ~clk;

    alu_seq #(.RESERVED_DATA(RSV)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .alu_enable(alu_enable), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry)
    );

    alu u_alu (
        .clk(clk), .reset(reset), .enable(alu_enable), .op(alu_op),
        .a(alu_a), .b(alu_b), .out(alu_out), .zero(alu_zero), .carry(alu_carry)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] data;
        logic        zero;
        logic        carry;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        zero;
        logic        carry;
        logic        err;
        int          lat;
        int          t_acc;
    } exp_t;

    exp_t sb[$];
    vec_t vt[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   alu_en_cnt = 0;
    logic prev_valid = 1'b0;

    function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] data, input logic z, input logic c,
                                input logic e, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.data = data;
        v.zero = z; v.carry = c; v.err = e; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: compare every RESP cycle against the scoreboard head
    always @(negedge clk) begin
        if (alu_enable) alu_en_cnt++;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual rsp_valid=1 required rsp_valid=0 (cycle %0d)", cyc);
            end else begin
                if (!prev_valid) chk("latency", cyc - sb[0].t_acc, sb[0].lat);
                chk("rsp_data", rsp_data, sb[0].data);
                chk("rsp_zero", rsp_zero, sb[0].zero);
                chk("rsp_carry", rsp_carry, sb[0].carry);
                chk("rsp_err", rsp_err, sb[0].err);
                if (rsp_ready) void'(sb.pop_front());
            end
        end
        prev_valid = rsp_valid;
    end

    task automatic send(input vec_t v);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual cmd_ready=0 required cmd_ready=1");
        end else begin
            e.data = v.data; e.zero = v.zero; e.carry = v.carry; e.err = v.err;
            e.lat = v.lat; e.t_acc = cyc;
            sb.push_back(e);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout actual pending=%0d required pending=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int     en0;
        int     n;
        vec_t   hv;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 16'd0; cmd_b = 16'd0;
        rsp_ready = 1'b1;

        // 8-bit ops; ADC carry-in comes from the previous ALU op
        vt.push_back(mk(4'd0, 16'h12F0, 16'h3420, 16'h0010, 1'b0, 1'b1, 1'b0, 3));
        vt.push_back(mk(4'd7, 16'h0001, 16'h0001, 16'h0003, 1'b0, 1'b0, 1'b0, 3));
        vt.push_back(mk(4'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 3));
        vt.push_back(mk(4'd1, 16'h0003, 16'h0005, 16'h00FE, 1'b0, 1'b1, 1'b0, 3));
        vt.push_back(mk(4'd2, 16'h00FF, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 3));
        vt.push_back(mk(4'd7, 16'h0010, 16'h0020, 16'h0031, 1'b0, 1'b0, 1'b0, 3));
        vt.push_back(mk(4'd3, 16'h0000, 16'h0000, 16'h00FF, 1'b0, 1'b1, 1'b0, 3));
        vt.push_back(mk(4'd3, 16'h0010, 16'h0000, 16'h000F, 1'b0, 1'b0, 1'b0, 3));
        vt.push_back(mk(4'd4, 16'h00F0, 16'h000F, 16'h0000, 1'b1, 1'b0, 1'b0, 3));
        vt.push_back(mk(4'd5, 16'h00A0, 16'h0005, 16'h00A5, 1'b0, 1'b0, 1'b0, 3));
        vt.push_back(mk(4'd6, 16'h00FF, 16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, 3));
        vt.push_back(mk(4'd7, 16'h0080, 16'h0080, 16'h0000, 1'b1, 1'b1, 1'b0, 3));
        vt.push_back(mk(4'd13, 16'h1234, 16'h5678, RSV, 1'b0, 1'b0, 1'b1, 1));
        vt.push_back(mk(4'd14, 16'hFFFF, 16'hFFFF, RSV, 1'b0, 1'b0, 1'b1, 1));
        vt.push_back(mk(4'd15, 16'h0000, 16'h0000, RSV, 1'b0, 1'b0, 1'b1, 1));
`ifdef ALU_SEQ_WIDE_EN
        vt.push_back(mk(4'd8,  16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 5));
        vt.push_back(mk(4'd8,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 5));
        vt.push_back(mk(4'd10, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 5));
        vt.push_back(mk(4'd10, 16'hFF00, 16'hF00F, 16'hF000, 1'b0, 1'b0, 1'b0, 5));
        vt.push_back(mk(4'd11, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 5));
        vt.push_back(mk(4'd12, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 5));
        hv = mk(4'd9, 16'h12FF, 16'h0000, 16'h1300, 1'b0, 1'b0, 1'b0, 5);
`else
        vt.push_back(mk(4'd8,  16'h00FF, 16'h0001, RSV, 1'b0, 1'b0, 1'b1, 1));
        vt.push_back(mk(4'd9,  16'h12FF, 16'h0000, RSV, 1'b0, 1'b0, 1'b1, 1));
        vt.push_back(mk(4'd10, 16'hF0F0, 16'h0FF0, RSV, 1'b0, 1'b0, 1'b1, 1));
        vt.push_back(mk(4'd11, 16'h1200, 16'h0034, RSV, 1'b0, 1'b0, 1'b1, 1));
        vt.push_back(mk(4'd12, 16'hFFFF, 16'hFFFF, RSV, 1'b0, 1'b0, 1'b1, 1));
        hv = mk(4'd9, 16'h12FF, 16'h0000, RSV, 1'b0, 1'b0, 1'b1, 1);
`endif

        // Reset behaviour
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_enable", alu_enable, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_rsp_carry", rsp_carry, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("idle_cmd_ready", cmd_ready, 1);

        // Table-driven vectors; ALU strobes: 1 per 8-bit, 2 per 16-bit, 0 reserved
        foreach (vt[i]) begin
            en0 = alu_en_cnt;
            send(vt[i]);
            wait_done();
            chk("alu_enable_count", alu_en_cnt - en0,
                (vt[i].lat == 1) ? 0 : ((vt[i].lat == 3) ? 1 : 2));
        end

        // INC16 with rsp_ready held low for 4 cycles
        rsp_ready = 1'b0;
        send(hv);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_rsp_valid", rsp_valid, 1);
        for (int k = 0; k < 4; k++) begin
            chk("hold_cmd_ready", cmd_ready, 0);
            @(posedge clk); #1;
        end
        chk("hold_rsp_valid_end", rsp_valid, 1);
        chk("hold_cmd_ready_end", cmd_ready, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_cmd_ready", cmd_ready, 1);
        chk("post_hs_rsp_valid", rsp_valid, 0);
        chk("post_hs_sb_empty", sb.size(), 0);
        sb.delete();

        // Reset while in WAIT_LO abandons the command
        send(mk(4'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 3));
        chk("issue_lo_enable", alu_enable, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_cmd_ready", cmd_ready, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_alu_enable", alu_enable, 0);
        reset = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        chk("midrst_idle", cmd_ready, 1);
        chk("midrst_rsp_data", rsp_data, 0);
        for (int k = 0; k < 4; k++) begin
            chk("midrst_no_rsp", rsp_valid, 0);
            @(posedge clk); #1;
        end
        send(mk(4'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 3));
        wait_done();
        send(mk(4'd0, 16'h0033, 16'h0044, 16'h0077, 1'b0, 1'b0, 1'b0, 3));
        wait_done();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter RESERVED_DATA, default 16'h0000, the rsp_data value returned for reserved or disabled commands.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_op in 4, cmd_a in 16, cmd_b in 16 forming the command channel, with a command accepted on cmd_valid & cmd_ready.
REQ-005 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out 16, rsp_zero out 1, rsp_carry out 1, rsp_err out 1 forming the response channel, with a response consumed on rsp_valid & rsp_ready.
REQ-006 SHALL have ALU-side ports alu_enable out 1, alu_op out 3, alu_a out 8, alu_b out 8, alu_out in 8, alu_zero in 1, alu_carry in 1, driving a registered 8-bit ALU whose result and flags update one cycle after alu_enable.

Function
REQ-007 SHALL use states IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, RESP.
REQ-008 SHALL drive cmd_ready = 1 only in IDLE, which excludes overlapping commands.
REQ-009 On accept, SHALL register cmd_op, cmd_a and cmd_b, then go to ISSUE_LO for valid commands or directly to RESP for reserved commands.
REQ-010 SHALL drive alu_enable = 1 only in ISSUE_LO and ISSUE_HI, each for exactly one cycle, and alu_op/alu_a/alu_b are don't-care elsewhere.
REQ-011 In ISSUE_LO, SHALL present the low bytes of the operands; in ISSUE_HI, SHALL present the high bytes.
REQ-012 In WAIT_LO and WAIT_HI, SHALL capture alu_out, alu_zero and alu_carry into the low or high half of the result.
REQ-013 Commands 0-7 SHALL pass through as the 8-bit ALU op (ADD, SUB, INC, DEC, AND, OR, XOR, ADC) on the low bytes only, and rsp_data = {8'h00, alu_out}.
REQ-014 For commands 0-7, rsp_zero and rsp_carry SHALL equal the captured ALU flags.
REQ-015 Command 8 (ADD16) SHALL issue ADD on the low bytes, then ADC on the high bytes.
REQ-016 Command 9 (INC16) SHALL issue INC on the low byte, then ADC on the high byte with alu_b = 0.
REQ-017 Commands 10, 11 and 12 (AND16, OR16, XOR16) SHALL issue the same logic op on both bytes.
REQ-018 For 16-bit commands, rsp_zero SHALL equal lo_zero & hi_zero.
REQ-019 For 16-bit commands, rsp_carry SHALL equal the high-byte carry for ADD16 and INC16, and 0 for the logic ops.
REQ-020 Commands 13-15 are reserved and SHALL produce a response with rsp_err = 1, rsp_data = RESERVED_DATA, and rsp_zero = rsp_carry = 0.
REQ-021 Latency SHALL be measured from the accept cycle T: for 8-bit commands, rsp_valid first asserts at T+3; for 16-bit commands, at T+5; for reserved commands, at T+1.
REQ-022 In RESP, SHALL hold rsp_valid and all rsp_* fields stable until rsp_ready is 1, then return to IDLE on the next cycle.
REQ-023 SHALL keep rsp_valid = 0 in every state other than RESP.

Reset
REQ-024 While reset = 1, SHALL enter IDLE on the next edge and clear all captured result bits and flags.
REQ-025 While reset = 1, SHALL hold cmd_ready = 0, rsp_valid = 0 and alu_enable = 0.
REQ-026 Reset mid-operation SHALL abandon the command with no response.
REQ-027 rsp_data, rsp_zero, rsp_carry and rsp_err SHALL read 0 after reset.

Configuration
REQ-028 Macro ALU_SEQ_WIDE_EN SHALL control whether 16-bit support is compiled in.
REQ-029 With ALU_SEQ_WIDE_EN defined, commands 8-12 SHALL behave as specified above.
REQ-030 Without ALU_SEQ_WIDE_EN, commands 8-12 SHALL be treated as reserved (REQ-020), the ISSUE_HI and WAIT_HI states and the high-half registers SHALL be absent, and commands 0-7 SHALL behave unchanged.

Structure
REQ-031 Package alu_pkg SHALL hold the 3-bit ALU op constants, the 4-bit sequencer command constants and the state enum.
REQ-032 alu_seq SHALL be a single module with no sub-module.
REQ-033 A test top SHALL instantiate alu_seq beside alu to close the loop.

Verification
REQ-034 ADD16 with a = 16'h00FF and b = 16'h0001 -> rsp_data = 16'h0100, zero = 0, carry = 0, rsp_valid at T+5.
REQ-035 ADD16 with a = 16'hFFFF and b = 16'h0001 -> rsp_data = 16'h0000, zero = 1, carry = 1.
REQ-036 Command 1 (SUB) with a = 16'h0005 and b = 16'h0005 -> rsp_data = 16'h0000, zero = 1, rsp_valid at T+3.
REQ-037 Command 14 (reserved) -> rsp_err = 1, rsp_data = RESERVED_DATA, rsp_valid at T+1, and alu_enable never asserts.
REQ-038 INC16 on 16'h12FF with rsp_ready held at 0 for 4 cycles -> rsp_data = 16'h1300 held stable throughout, and cmd_ready stays 0 until the cycle after the handshake.
REQ-039 Reset asserted in WAIT_LO -> next cycle in IDLE, no response, and the following command completes correctly.
